regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, number of registers (power of two, >=2); AW = log2(NREG).
REQ-003 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port we, input, 1, writeback enable.
REQ-006 SHALL have port rd, input, AW, writeback address.
REQ-007 SHALL have port wd, input, XLEN, writeback data.
REQ-008 SHALL have ports rs1 and rs2, input, AW each, read addresses.
REQ-009 SHALL have ports rd1 and rd2, output, XLEN each, read data.
REQ-010 SHALL have port iss_valid, input, 1, an instruction writing iss_rd is issued this cycle.
REQ-011 SHALL have port iss_rd, input, AW, destination of the issued instruction.
REQ-012 SHALL have ports rs1_busy and rs2_busy, output, 1 each, source has a pending write.
REQ-013 SHALL have port iss_rd_busy, output, 1, iss_rd already has a pending write (WAW).
REQ-014 SHALL have port busy_cnt, output, AW+1, number of registers currently pending.

Function
REQ-015 SHALL hold NREG x XLEN registers; register 0 SHALL always read 0 and SHALL ignore writes.
REQ-016 SHALL write wd to register rd on the rising clk edge when we=1 and rd!=0.
REQ-017 SHALL return rd1/rd2 combinationally from the register array (zero latency).
REQ-018 SHALL keep one busy bit per register; bit 0 is constant 0.
REQ-019 SHALL set busy[iss_rd] at the clock edge when iss_valid=1 and iss_rd!=0.
REQ-020 SHALL clear busy[rd] at the clock edge when we=1 and rd!=0.
REQ-021 SHALL leave busy[r] set when issue and writeback target the same r in one cycle (the new issue wins).
REQ-022 SHALL drive rs1_busy/rs2_busy/iss_rd_busy combinationally as busy[addr], forced to 0 for address 0.
REQ-023 SHALL update busy_cnt by +1 for each 0->1 busy transition and -1 for each 1->0 transition in the same edge (net 0 when both occur on different registers); busy_cnt SHALL always equal the popcount of busy.
REQ-024 SHALL ignore a writeback to a non-busy register for scoreboard purposes (no underflow); the data write still occurs.
REQ-025 SHALL ignore an issue to an already-busy register for busy_cnt (no double count); the bit stays set.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously clear all registers to 0, all busy bits to 0 and busy_cnt to 0.
REQ-027 SHALL discard any write or issue coinciding with reset; the first write takes effect on the first rising edge with rst_n=1.

Configuration
REQ-028 SHALL honour macro REGFILE_SB_BYPASS_EN.
REQ-029 With REGFILE_SB_BYPASS_EN defined, SHALL forward wd to rd1/rd2 when we=1, rd!=0 and rd equals rs1/rs2, and SHALL force the matching rs1_busy/rs2_busy to 0 in that cycle.
REQ-030 Without REGFILE_SB_BYPASS_EN, rd1/rd2 SHALL show the array contents only (new value visible the cycle after the write), and busy outputs SHALL reflect busy bits unmodified.

Verification
REQ-031 Reset: assert rst_n=0 mid-run with registers written -> all rd1/rd2 reads 0, busy_cnt=0, all busy outputs 0.
REQ-032 Write/read: we=1, rd=5, wd=0xDEADBEEF, then rs1=5 next cycle -> rd1=0xDEADBEEF; write to rd=0 with 0x1234 -> rs2=0 reads 0.
REQ-033 Bypass: same cycle we=1, rd=7, wd=0xA5A5A5A5, rs1=7 -> rd1=0xA5A5A5A5 and rs1_busy=0 with REGFILE_SB_BYPASS_EN; without it, old value and busy unchanged.
REQ-034 Scoreboard: issue rd=3, then rd=4 -> busy_cnt=2, rs1=3 gives rs1_busy=1; writeback rd=3 -> busy_cnt=1, rs1_busy=0.
REQ-035 Simultaneous: busy[9]=1, issue 9 and writeback 9 same cycle -> busy[9] stays 1, busy_cnt unchanged; issue 10 and writeback 9 same cycle -> busy_cnt unchanged, busy[10]=1, busy[9]=0.
REQ-036 Corner: writeback to non-busy rd=12 -> busy_cnt stays 0; issue iss_rd=0 -> iss_rd_busy=0 and busy_cnt stays 0; NREG=16, XLEN=64 build passes REQ-032 and REQ-034.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with per-register pending-write scoreboard (busy bits + busy count).
// Optional same-cycle writeback forwarding is enabled by defining REGFILE_SB_BYPASS_EN.
module regfile_sb #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] wd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            iss_rd_busy,
    output logic [AW:0]     busy_cnt
);

    localparam logic [AW-1:0]   ZERO_ADDR = {AW{1'b0}};
    localparam logic [XLEN-1:0] ZERO_DATA = {XLEN{1'b0}};

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [AW:0]     cnt_q;
    logic [AW:0]     cnt_d;

    logic            wr_en_s;
    logic            iss_en_s;
    logic            cnt_inc_s;
    logic            cnt_dec_s;
    logic [XLEN-1:0] arr_rd1_s;
    logic [XLEN-1:0] arr_rd2_s;
    logic            arr_rs1_busy_s;
    logic            arr_rs2_busy_s;

    function automatic logic [AW:0] next_count(input logic [AW:0] cnt,
                                               input logic        inc,
                                               input logic        dec);
        return cnt + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
    endfunction

    assign wr_en_s  = we && (rd != ZERO_ADDR);
    assign iss_en_s = iss_valid && (iss_rd != ZERO_ADDR);

    // Register array write port; entry 0 is never written because wr_en_s excludes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= ZERO_DATA;
            end
        end else if (wr_en_s) begin
            regs_q[rd] <= wd;
        end
    end

    // Busy-bit next state: clear on writeback first, so a same-register issue wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_s) begin
            busy_d[rd] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        if (iss_en_s) begin
            busy_d[iss_rd] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;
    end

    // Count only real transitions: a re-issue or a writeback to an idle register is neutral.
    always_comb begin
        cnt_inc_s = 1'b0;
        cnt_dec_s = 1'b0;
        if (iss_en_s && !busy_q[iss_rd]) begin
            cnt_inc_s = 1'b1;
        end else begin
            cnt_inc_s = 1'b0;
        end
        if (wr_en_s && busy_q[rd] && !(iss_en_s && (iss_rd == rd))) begin
            cnt_dec_s = 1'b1;
        end else begin
            cnt_dec_s = 1'b0;
        end
        cnt_d = next_count(cnt_q, cnt_inc_s, cnt_dec_s);
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= {NREG{1'b0}};
            cnt_q  <= {(AW+1){1'b0}};
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Array read ports and raw busy lookups; address 0 is forced to zero / not busy.
    always_comb begin
        arr_rd1_s      = (rs1 == ZERO_ADDR) ? ZERO_DATA : regs_q[rs1];
        arr_rd2_s      = (rs2 == ZERO_ADDR) ? ZERO_DATA : regs_q[rs2];
        arr_rs1_busy_s = (rs1 == ZERO_ADDR) ? 1'b0 : busy_q[rs1];
        arr_rs2_busy_s = (rs2 == ZERO_ADDR) ? 1'b0 : busy_q[rs2];
        iss_rd_busy    = (iss_rd == ZERO_ADDR) ? 1'b0 : busy_q[iss_rd];
    end

`ifdef REGFILE_SB_BYPASS_EN
    // Forward the in-flight writeback to matching readers and hide its busy bit.
    always_comb begin
        if (wr_en_s && (rd == rs1)) begin
            rd1      = wd;
            rs1_busy = 1'b0;
        end else begin
            rd1      = arr_rd1_s;
            rs1_busy = arr_rs1_busy_s;
        end
        if (wr_en_s && (rd == rs2)) begin
            rd2      = wd;
            rs2_busy = 1'b0;
        end else begin
            rd2      = arr_rd2_s;
            rs2_busy = arr_rs2_busy_s;
        end
    end
`else
    assign rd1      = arr_rd1_s;
    assign rd2      = arr_rd2_s;
    assign rs1_busy = arr_rs1_busy_s;
    assign rs2_busy = arr_rs2_busy_s;
`endif

    assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default 32x32 instance plus a 16x64 instance.
module tb_regfile_sb;

    logic        clk;
    logic        rst_n;
    int          checks;
    int          errors;

    // default instance (XLEN=32, NREG=32)
    logic        we, iss_valid;
    logic [4:0]  rd, rs1, rs2, iss_rd;
    logic [31:0] wd, rd1, rd2;
    logic        rs1_busy, rs2_busy, iss_rd_busy;
    logic [5:0]  busy_cnt;

    // wide/narrow instance (XLEN=64, NREG=16)
    logic        b_we, b_iss_valid;
    logic [3:0]  b_rd, b_rs1, b_rs2, b_iss_rd;
    logic [63:0] b_wd, b_rd1, b_rd2;
    logic        b_rs1_busy, b_rs2_busy, b_iss_rd_busy;
    logic [4:0]  b_busy_cnt;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_sb dut (
        .clk(clk), .rst_n(rst_n), .we(we), .rd(rd), .wd(wd),
        .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .iss_rd_busy(iss_rd_busy), .busy_cnt(busy_cnt)
    );

    regfile_sb #(.XLEN(64), .NREG(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .we(b_we), .rd(b_rd), .wd(b_wd),
        .rs1(b_rs1), .rs2(b_rs2), .rd1(b_rd1), .rd2(b_rd2),
        .iss_valid(b_iss_valid), .iss_rd(b_iss_rd),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
        .iss_rd_busy(b_iss_rd_busy), .busy_cnt(b_busy_cnt)
    );

    initial clk = 1'b0;
    // Free-running clock.
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end else begin
            checks = checks;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        we = 1'b0; rd = 5'd0; wd = 32'd0; rs1 = 5'd5; rs2 = 5'd0;
        iss_valid = 1'b0; iss_rd = 5'd0;
        b_we = 1'b0; b_rd = 4'd0; b_wd = 64'd0; b_rs1 = 4'd0; b_rs2 = 4'd0;
        b_iss_valid = 1'b0; b_iss_rd = 4'd0;

        step();
        chk("reset_cnt", busy_cnt, 6'd0);
        chk("reset_rd1", rd1, 32'd0);
        rst_n = 1'b1;

        // write 5, read next cycle
        we = 1'b1; rd = 5'd5; wd = 32'hDEADBEEF; rs1 = 5'd5;
        #1;
        chk("wr5_same_cycle", rd1, BYP ? 32'hDEADBEEF : 32'd0);
        step();
        we = 1'b0; #1;
        chk("wr5_read", rd1, 32'hDEADBEEF);

        // write to r0 is ignored
        we = 1'b1; rd = 5'd0; wd = 32'h1234; rs2 = 5'd0;
        step();
        we = 1'b0; #1;
        chk("r0_read", rd2, 32'd0);
        chk("r0_cnt", busy_cnt, 6'd0);

        // bypass case on a busy register
        iss_valid = 1'b1; iss_rd = 5'd7;
        step();
        iss_valid = 1'b0; #1;
        chk("iss7_cnt", busy_cnt, 6'd1);
        we = 1'b1; rd = 5'd7; wd = 32'hA5A5A5A5; rs1 = 5'd7;
        #1;
        chk("byp_rd1", rd1, BYP ? 32'hA5A5A5A5 : 32'd0);
        chk("byp_rs1_busy", rs1_busy, BYP ? 1'b0 : 1'b1);
        step();
        we = 1'b0; #1;
        chk("wb7_rd1", rd1, 32'hA5A5A5A5);
        chk("wb7_busy", rs1_busy, 1'b0);
        chk("wb7_cnt", busy_cnt, 6'd0);

        // scoreboard: issue 3, issue 4, writeback 3
        iss_valid = 1'b1; iss_rd = 5'd3;
        step();
        iss_rd = 5'd4;
        step();
        iss_valid = 1'b0; iss_rd = 5'd3; rs1 = 5'd3; rs2 = 5'd4; #1;
        chk("sb_cnt2", busy_cnt, 6'd2);
        chk("sb_rs1_busy3", rs1_busy, 1'b1);
        chk("sb_waw3", iss_rd_busy, 1'b1);
        we = 1'b1; rd = 5'd3; wd = 32'h33;
        step();
        we = 1'b0; #1;
        chk("sb_cnt1", busy_cnt, 6'd1);
        chk("sb_rs1_free3", rs1_busy, 1'b0);
        chk("sb_rs2_busy4", rs2_busy, 1'b1);

        // simultaneous issue/writeback
        iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        #1;
        chk("sim_cnt_a", busy_cnt, 6'd2);
        we = 1'b1; rd = 5'd9; wd = 32'h99; iss_rd = 5'd9;
        step();
        rs1 = 5'd9; #1;
        chk("sim_same_cnt", busy_cnt, 6'd2);
        chk("sim_same_busy9", rs1_busy, BYP ? 1'b0 : 1'b1);
        iss_rd = 5'd10;
        step();
        we = 1'b0; iss_valid = 1'b0; rs2 = 5'd10; #1;
        chk("sim_diff_cnt", busy_cnt, 6'd2);
        chk("sim_diff_busy9", rs1_busy, 1'b0);
        chk("sim_diff_busy10", rs2_busy, 1'b1);

        // drain 4 and 10
        we = 1'b1; rd = 5'd4; wd = 32'h44;
        step();
        rd = 5'd10; wd = 32'hAA;
        step();
        we = 1'b0; #1;
        chk("drain_cnt", busy_cnt, 6'd0);

        // writeback to idle register: no underflow, data still written
        we = 1'b1; rd = 5'd12; wd = 32'h00C0FFEE;
        step();
        we = 1'b0; rs1 = 5'd12; #1;
        chk("idle_wb_cnt", busy_cnt, 6'd0);
        chk("idle_wb_data", rd1, 32'h00C0FFEE);

        // issue to r0
        iss_valid = 1'b1; iss_rd = 5'd0; #1;
        chk("iss0_waw", iss_rd_busy, 1'b0);
        step();
        iss_valid = 1'b0; #1;
        chk("iss0_cnt", busy_cnt, 6'd0);

        // double issue counts once
        iss_valid = 1'b1; iss_rd = 5'd6;
        step();
        step();
        iss_valid = 1'b0; rs2 = 5'd6; #1;
        chk("dbl_iss_cnt", busy_cnt, 6'd1);
        chk("dbl_iss_busy", rs2_busy, 1'b1);

        // mid-run reset with a write held across an edge
        we = 1'b1; rd = 5'd5; wd = 32'h55; rs1 = 5'd5;
        rst_n = 1'b0; #1;
        chk("mr_rd1", rd1, BYP ? 32'h55 : 32'd0);
        step();
        we = 1'b0; #1;
        chk("mr_rd1_held", rd1, 32'd0);
        chk("mr_cnt", busy_cnt, 6'd0);
        chk("mr_busy6", rs2_busy, 1'b0);
        rs2 = 5'd12; #1;
        chk("mr_rd2", rd2, 32'd0);
        we = 1'b1; wd = 32'h56;
        rst_n = 1'b1;
        step();
        we = 1'b0; #1;
        chk("post_rst_wr", rd1, 32'h56);

        // 16 x 64 instance
        b_we = 1'b1; b_rd = 4'd5; b_wd = 64'hDEADBEEF_CAFEF00D; b_rs1 = 4'd5;
        step();
        b_we = 1'b0; #1;
        chk("b_wr5", b_rd1, 64'hDEADBEEF_CAFEF00D);
        b_we = 1'b1; b_rd = 4'd0; b_wd = 64'h1234; b_rs2 = 4'd0;
        step();
        b_we = 1'b0; #1;
        chk("b_r0", b_rd2, 64'd0);
        b_iss_valid = 1'b1; b_iss_rd = 4'd3;
        step();
        b_iss_rd = 4'd4;
        step();
        b_iss_valid = 1'b0; b_rs1 = 4'd3; #1;
        chk("b_cnt2", b_busy_cnt, 5'd2);
        chk("b_busy3", b_rs1_busy, 1'b1);
        b_we = 1'b1; b_rd = 4'd3; b_wd = 64'h3;
        step();
        b_we = 1'b0; #1;
        chk("b_cnt1", b_busy_cnt, 5'd1);
        chk("b_free3", b_rs1_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
